// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter slice.
//   BCD_MAX / BCD_MIN : legal decade range of one digit
//   bcd_digit_t       : one packed BCD digit
//   bcd_clamp()       : maps the non-decimal codes 10..15 onto 9
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter.
//   Clock, Clear : clock, async active-high reset
//   sclr         : synchronous clear (highest priority at the edge)
//   load         : load bcd_clamp(load_val)
//   inc / dec    : step up / down by one with decade wrap (9->0, 0->9)
//   digit        : current digit, always 0..9
//   is9 / is0    : digit is at the top / bottom of its decade
// The top level never asserts inc and dec together; inc wins if it did.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       Clock,
    input  logic       Clear,
    input  logic       sclr,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       inc,
    input  logic       dec,
    output bcd_digit_t digit,
    output logic       is9,
    output logic       is0
);

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            digit <= BCD_MIN;
        else if (sclr)
            digit <= BCD_MIN;
        else if (load)
            digit <= bcd_clamp(load_val);
        else if (inc)
            // >= rather than == so a stray code can never climb past 9
            digit <= (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
        else if (dec)
            digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end

    assign is9 = (digit == BCD_MAX);
    assign is0 = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit BCD up/down counter.
//   DIGITS   : number of decades (1..8)
//   SATURATE : 1 = hold at the terminal value, 0 = wrap
//   Clock    : clock, all updates on the rising edge
//   Clear    : async active-high reset
//   Sclr     : synchronous clear   (priority Sclr > Load > E)
//   Load     : load LoadVal, each digit clamped to 9; clears TC/Overflow
//   LoadVal  : load value, digit k at [4k+3:4k]
//   E, Dir   : count enable, direction (0 up, 1 down)
//   BCD      : count value, packed like LoadVal
//   Zero     : combinational all-digits-zero
//   TC       : registered pulse for each edge that sees a terminal event
//   Overflow : sticky terminal-event flag
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Sclr,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    input  logic                  E,
    input  logic                  Dir,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Zero,
    output logic                  TC,
    output logic                  Overflow
);

    localparam logic SAT = SATURATE;

    bcd_digit_t [DIGITS-1:0] dig;
    logic       [DIGITS-1:0] is9, is0, inc, dec;

    // c9[k] / c0[k]: all digits below k are 9 / 0. Index DIGITS spans the
    // whole counter, which is exactly the terminal-value test.
    logic [DIGITS:0] c9, c0;
    logic            all9, all0, term, hold;

    assign c9[0] = 1'b1;
    assign c0[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dig
            assign c9[k+1] = c9[k] & is9[k];
            assign c0[k+1] = c0[k] & is0[k];

            // In saturate mode the terminal step is suppressed entirely, so
            // the all-9 / all-0 pattern simply holds.
            assign inc[k] = E & ~Dir & c9[k] & ~hold;
            assign dec[k] = E &  Dir & c0[k] & ~hold;

            bcd_digit u_digit (
                .Clock    (Clock),
                .Clear    (Clear),
                .sclr     (Sclr),
                .load     (Load),
                .load_val (LoadVal[4*k +: 4]),
                .inc      (inc[k]),
                .dec      (dec[k]),
                .digit    (dig[k]),
                .is9      (is9[k]),
                .is0      (is0[k])
            );
        end
    endgenerate

    assign all9 = c9[DIGITS];
    assign all0 = c0[DIGITS];

    // Terminal event is only meaningful when counting; Sclr/Load override it
    // in the flag register below.
    assign term = E & (Dir ? all0 : all9);
    assign hold = term & SAT;

    assign BCD  = dig;
    assign Zero = all0;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            TC       <= 1'b0;
            Overflow <= 1'b0;
        end else if (Sclr || Load) begin
            TC       <= 1'b0;
            Overflow <= 1'b0;
        end else if (term) begin
            TC       <= 1'b1;
            Overflow <= 1'b1;
        end else begin
            TC       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: four instances (4-digit wrap, 4-digit saturate,
// 1-digit wrap, 8-digit wrap) share one stimulus and are compared every
// cycle against an integer-valued reference model.
module tb_bcd_counter_n;

    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        clr, sclr, load, e, dir;
    logic [31:0] lv;
    logic [15:0] b0, b1;
    logic [3:0]  b2;
    logic [31:0] b3;
    logic [3:0]  z, tc, ov;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u_w4 (
        .Clock(Clock), .Clear(clr), .Sclr(sclr), .Load(load), .LoadVal(lv[15:0]),
        .E(e), .Dir(dir), .BCD(b0), .Zero(z[0]), .TC(tc[0]), .Overflow(ov[0]));
    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1)) u_s4 (
        .Clock(Clock), .Clear(clr), .Sclr(sclr), .Load(load), .LoadVal(lv[15:0]),
        .E(e), .Dir(dir), .BCD(b1), .Zero(z[1]), .TC(tc[1]), .Overflow(ov[1]));
    bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_w1 (
        .Clock(Clock), .Clear(clr), .Sclr(sclr), .Load(load), .LoadVal(lv[3:0]),
        .E(e), .Dir(dir), .BCD(b2), .Zero(z[2]), .TC(tc[2]), .Overflow(ov[2]));
    bcd_counter_n #(.DIGITS(8), .SATURATE(1'b0)) u_w8 (
        .Clock(Clock), .Clear(clr), .Sclr(sclr), .Load(load), .LoadVal(lv),
        .E(e), .Dir(dir), .BCD(b3), .Zero(z[3]), .TC(tc[3]), .Overflow(ov[3]));

    function automatic int nd(input int i);
        case (i)
            0, 1:    return 4;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic bit ns(input int i);
        return (i == 1);
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int j = 0; j < n; j++) r = r * 10;
        return r;
    endfunction

    // Load value as an integer, each nibble limited to 9
    function automatic int clampv(input logic [31:0] v, input int d);
        int r = 0;
        int x;
        for (int j = 0; j < d; j++) begin
            x = int'(v[4*j +: 4]);
            if (x > 9) x = 9;
            r = r + x * pow10(j);
        end
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        for (int j = 0; j < d; j++) r[4*j +: 4] = 4'((v / pow10(j)) % 10);
        return r;
    endfunction

    function automatic logic [31:0] get_bcd(input int i);
        case (i)
            0:       return {16'h0, b0};
            1:       return {16'h0, b1};
            2:       return {28'h0, b2};
            default: return b3;
        endcase
    endfunction

    // Reference model: counter value as a plain integer modulo 10^DIGITS
    int mval[4];
    bit mtc[4];
    bit movf[4];

    task automatic step(input int i);
        int mx;
        mx = pow10(nd(i)) - 1;
        if (sclr) begin
            mval[i] = 0; mtc[i] = 0; movf[i] = 0;
        end else if (load) begin
            mval[i] = clampv(lv, nd(i)); mtc[i] = 0; movf[i] = 0;
        end else if (e) begin
            if (!dir && mval[i] == mx) begin
                mtc[i] = 1; movf[i] = 1; mval[i] = ns(i) ? mx : 0;
            end else if (dir && mval[i] == 0) begin
                mtc[i] = 1; movf[i] = 1; mval[i] = ns(i) ? 0 : mx;
            end else begin
                mtc[i] = 0; mval[i] = dir ? mval[i] - 1 : mval[i] + 1;
            end
        end else begin
            mtc[i] = 0;
        end
    endtask

    always @(posedge Clock or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                mval[i] = 0; mtc[i] = 0; movf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) step(i);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bcd%0d", i),  get_bcd(i), to_bcd(mval[i], nd(i)));
            chk($sformatf("zero%0d", i), {31'h0, z[i]},  {31'h0, mval[i] == 0});
            chk($sformatf("tc%0d", i),   {31'h0, tc[i]}, {31'h0, mtc[i]});
            chk($sformatf("ovf%0d", i),  {31'h0, ov[i]}, {31'h0, movf[i]});
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
        check_all();
    endtask

    logic [15:0] exp_up [3];
    logic [15:0] exp_dn [4];
    logic [3:0]  exp_tcd;

    initial begin
        clr = 1'b1; sclr = 1'b0; load = 1'b0; e = 1'b0; dir = 1'b0; lv = '0;
        #12;
        check_all();
        chk("reset_zero", {28'h0, z}, 32'hF);

        // Count up 1234 edges from reset
        @(negedge Clock);
        clr = 1'b0; e = 1'b1; dir = 1'b0;
        repeat (1234) cyc();
        chk("cnt1234", {16'h0, b0}, 32'h1234);
        chk("cnt1234_zero", {31'h0, z[0]}, 32'h0);

        // Wrap-up on all wrapping widths: 1, 4 and 8 digits
        e = 1'b0; load = 1'b1; lv = 32'h99999998;
        cyc();
        load = 1'b0; e = 1'b1;
        exp_up[0] = 16'h9999; exp_up[1] = 16'h0000; exp_up[2] = 16'h0001;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("wrap4", {16'h0, b0}, {16'h0, exp_up[c]});
            chk("wrap4_tc", {31'h0, tc[0]}, {31'h0, c == 1});
            chk("wrap1", {28'h0, b2}, {28'h0, exp_up[c][3:0]});
            chk("wrap8", b3, (c == 0) ? 32'h99999999 : {16'h0, exp_up[c]});
            chk("wrap8_tc", {31'h0, tc[3]}, {31'h0, c == 1});
            if (c > 0) chk("wrap4_ovf", {31'h0, ov[0]}, 32'h1);
        end

        // Saturate down from 0002
        e = 1'b0; load = 1'b1; lv = 32'h0002;
        cyc();
        load = 1'b0; e = 1'b1; dir = 1'b1;
        exp_dn[0] = 16'h0001; exp_dn[1] = 16'h0000; exp_dn[2] = 16'h0000; exp_dn[3] = 16'h0000;
        exp_tcd = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("satdn", {16'h0, b1}, {16'h0, exp_dn[c]});
            chk("satdn_tc", {31'h0, tc[1]}, {31'h0, exp_tcd[c]});
        end
        chk("satdn_zero", {31'h0, z[1]}, 32'h1);

        // Load clamp with E high, then Sclr over Load
        load = 1'b1; e = 1'b1; dir = 1'b0; lv = 32'h0000A3F5;
        cyc();
        chk("clamp4", {16'h0, b0}, 32'h9395);
        chk("clamp8", b3, 32'h00009395);
        sclr = 1'b1;
        cyc();
        chk("sclr_load", {16'h0, b0}, 32'h0);
        sclr = 1'b0; load = 1'b0;

        // Async Clear between edges while counting from 0456
        e = 1'b0; load = 1'b1; lv = 32'h0456;
        cyc();
        load = 1'b0; e = 1'b1;
        #2 clr = 1'b1;
        #1;
        chk("async_bcd", {16'h0, b0}, 32'h0);
        chk("async_ovf", {31'h0, ov[0]}, 32'h0);
        check_all();
        repeat (2) cyc();
        chk("clear_hold", {16'h0, b0}, 32'h0);
        clr = 1'b0;

        // Random traffic
        repeat (3000) begin
            sclr = ($urandom % 40) == 0;
            load = ($urandom % 8) == 0;
            e    = ($urandom % 4) != 0;
            dir  = ($urandom % 3) == 0;
            for (int j = 0; j < 8; j++) lv[4*j +: 4] = 4'($urandom % 12);
            if (($urandom % 100) == 0) begin
                #2 clr = 1'b1;
                #2 clr = 1'b0;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
